vector_loader: RTL and testbench
================================

VECTOR_LOADER -- requirements
Module: vector_loader

Interface
REQ-001 SHALL have parameter VECTOR_LENGTH, default 16, number of lanes per packed vector.
REQ-002 SHALL have parameter FIXED_POINT_LENGTH, default 16, bit width of one fixed-point element.
REQ-003 SHALL have port clk_in  input  1  sole clock; all state updates on its rising edge.
REQ-004 SHALL have port reset_i  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port flush_in  input  1  synchronous abort of the current fill.
REQ-006 SHALL have port elem_1_in  input  FIXED_POINT_LENGTH  element of vector 1.
REQ-007 SHALL have port elem_2_in  input  FIXED_POINT_LENGTH  element of vector 2.
REQ-008 SHALL have port elem_valid_in  input  1  element pair present.
REQ-009 SHALL have port elem_last_in  input  1  current pair is the final pair of this vector.
REQ-010 SHALL have port elem_ready_out  output  1  loader accepts a pair this cycle.
REQ-011 SHALL have port vector_1_out  output  VECTOR_LENGTH*FIXED_POINT_LENGTH  packed vector 1, feeds vector_multiplier vector_1_in.
REQ-012 SHALL have port vector_2_out  output  VECTOR_LENGTH*FIXED_POINT_LENGTH  packed vector 2, feeds vector_multiplier vector_2_in.
REQ-013 SHALL have port vector_valid_out  output  1  packed vectors complete and stable.
REQ-014 SHALL have port vector_ready_in  input  1  consumer takes the packed vectors.
REQ-015 SHALL have port count_out  output  $clog2(VECTOR_LENGTH+1)  number of pairs captured in current vector.

Function
REQ-016 SHALL implement two states: FILL (elem_ready_out=1, vector_valid_out=0) and HOLD (elem_ready_out=0, vector_valid_out=1); both outputs decoded from registered state only.
REQ-017 SHALL accept a pair on a rising edge in FILL with elem_valid_in=1; pair at index i written to bits [i*FIXED_POINT_LENGTH +: FIXED_POINT_LENGTH] of each output vector; index and count_out increment by 1.
REQ-018 SHALL transition FILL->HOLD on the edge accepting index VECTOR_LENGTH-1, or on accepting any pair with elem_last_in=1; vector_valid_out asserts the following cycle.
REQ-019 SHALL leave lanes not written in a short vector (early last) at zero; count_out reports the true pair count.
REQ-020 SHALL ignore elem_last_in when elem_valid_in=0 and ignore elem inputs entirely in HOLD.
REQ-021 SHALL hold vector_1_out, vector_2_out, count_out constant throughout HOLD.
REQ-022 SHALL transition HOLD->FILL on an edge with vector_ready_in=1; same edge clears all lanes to zero, index and count_out to 0.
REQ-023 SHALL give latency of exactly one cycle from the final accepted pair to vector_valid_out=1, and minimum period VECTOR_LENGTH+1 cycles per full vector with vector_ready_in held high.
REQ-024 SHALL, on flush_in=1, override all other inputs: next state FILL, lanes, index and count_out cleared, no pair captured that edge, pending HOLD vector discarded.
REQ-025 SHALL never let the index exceed VECTOR_LENGTH-1 or wrap; no pair accepted beyond lane VECTOR_LENGTH-1.
REQ-026 SHALL treat elements as opaque bit patterns (no sign extension, rounding or arithmetic).

Reset
REQ-027 SHALL, while reset_i=0, asynchronously force state FILL, all lanes 0, index 0, count_out 0, vector_valid_out 0; elem_ready_out=1 from first edge after reset_i rises.
REQ-028 SHALL abandon any partial or held vector on reset assertion mid-operation with no output pulse.

Verification
REQ-029 SHALL cover full load: 16 pairs elem_1=i, elem_2=16+i, last only on i=15 -> one cycle later vector_valid_out=1, lane i holds i / 16+i, count_out=16.
REQ-030 SHALL cover short vector: 3 pairs 0x0400,0x0800,0x0C00 with last on third -> valid next cycle, lanes 0..2 set, lanes 3..15 = 0, count_out=3.
REQ-031 SHALL cover backpressure: vector_ready_in=0 for 5 cycles in HOLD -> outputs stable, elem_ready_out=0, elem_valid_in pairs not captured; ready_in=1 -> next cycle FILL, all lanes 0.
REQ-032 SHALL cover back-to-back: two full vectors, vector_ready_in tied 1 -> second vector_valid_out rises 17 cycles after the first.
REQ-033 SHALL cover flush after 7 pairs, and flush in HOLD -> count_out=0, lanes 0, vector_valid_out=0 next cycle.
REQ-034 SHALL cover reset_i pulsed low mid-fill (between edges) -> outputs zero immediately, before next clock edge.

Source files
------------

// File: rtl/vector_loader.sv
// Collects element pairs into two packed vectors, then holds them until the
// consumer takes them. One lane register pair per vector slot.

module vector_loader_lane #(
   parameter int W = 16
) (
   input  logic         i_clk,
   input  logic         i_rst_n,
   input  logic         i_clr,
   input  logic         i_we,
   input  logic [W-1:0] i_d1,
   input  logic [W-1:0] i_d2,
   output logic [W-1:0] o_q1,
   output logic [W-1:0] o_q2
);
   logic [W-1:0] r_q1, r_q2;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         r_q1 <= '0;
         r_q2 <= '0;
      end else if (i_clr) begin
         r_q1 <= '0;
         r_q2 <= '0;
      end else if (i_we) begin
         r_q1 <= i_d1;
         r_q2 <= i_d2;
      end
   end

   assign o_q1 = r_q1;
   assign o_q2 = r_q2;
endmodule

module vector_loader #(
   parameter int VECTOR_LENGTH      = 16,
   parameter int FIXED_POINT_LENGTH = 16
) (
   input  logic                                        clk_in,
   input  logic                                        reset_i,
   input  logic                                        flush_in,
   input  logic [FIXED_POINT_LENGTH-1:0]               elem_1_in,
   input  logic [FIXED_POINT_LENGTH-1:0]               elem_2_in,
   input  logic                                        elem_valid_in,
   input  logic                                        elem_last_in,
   output logic                                        elem_ready_out,
   output logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_1_out,
   output logic [VECTOR_LENGTH*FIXED_POINT_LENGTH-1:0] vector_2_out,
   output logic                                        vector_valid_out,
   input  logic                                        vector_ready_in,
   output logic [$clog2(VECTOR_LENGTH+1)-1:0]          count_out
);
   localparam int CNT_W = $clog2(VECTOR_LENGTH+1);
   localparam int FL    = FIXED_POINT_LENGTH;

   typedef enum logic {S_FILL = 1'b0, S_HOLD = 1'b1} state_t;

   state_t           r_state, w_next_state;
   logic [CNT_W-1:0] r_count;
   logic             w_accept, w_last_lane, w_done, w_clear;

   // Flush wins over everything, so it also blocks capture on its edge.
   assign w_accept    = (r_state == S_FILL) && elem_valid_in && !flush_in;
   assign w_last_lane = (r_count == CNT_W'(VECTOR_LENGTH-1));
   assign w_done      = w_accept && (elem_last_in || w_last_lane);
   assign w_clear     = flush_in || ((r_state == S_HOLD) && vector_ready_in);

   always_ff @(posedge clk_in or negedge reset_i) begin
      if (!reset_i) r_state <= S_FILL;
      else          r_state <= w_next_state;
   end

   always_comb begin
      w_next_state = r_state;
      if (flush_in) begin
         w_next_state = S_FILL;
      end else begin
         case (r_state)
            S_FILL:  if (w_done) w_next_state = S_HOLD;
            S_HOLD:  if (vector_ready_in) w_next_state = S_FILL;
            default: w_next_state = S_FILL;
         endcase
      end
   end

   always_comb begin
      elem_ready_out   = 1'b0;
      vector_valid_out = 1'b0;
      case (r_state)
         S_FILL:  elem_ready_out   = 1'b1;
         S_HOLD:  vector_valid_out = 1'b1;
         default: elem_ready_out   = 1'b1;
      endcase
   end

   // Count doubles as the write index; it never passes VECTOR_LENGTH because
   // accepting the last lane always moves to HOLD.
   always_ff @(posedge clk_in or negedge reset_i) begin
      if (!reset_i)      r_count <= '0;
      else if (w_clear)  r_count <= '0;
      else if (w_accept) r_count <= r_count + 1'b1;
   end

   assign count_out = r_count;

   for (genvar g = 0; g < VECTOR_LENGTH; g++) begin : g_lane
      logic w_we;
      assign w_we = w_accept && (r_count == CNT_W'(g));
      vector_loader_lane #(.W(FL)) u_lane (
         .i_clk   (clk_in),
         .i_rst_n (reset_i),
         .i_clr   (w_clear),
         .i_we    (w_we),
         .i_d1    (elem_1_in),
         .i_d2    (elem_2_in),
         .o_q1    (vector_1_out[g*FL +: FL]),
         .o_q2    (vector_2_out[g*FL +: FL])
      );
   end
endmodule

// File: tb/tb_vector_loader.sv
// Directed bench for vector_loader: completed vectors are queued on issue and
// popped by a monitor at each consumer handshake.

module tb_vector_loader;
   localparam int VL = 16;
   localparam int FL = 16;
   localparam int VW = VL*FL;
   localparam int CW = $clog2(VL+1);

   logic          clk = 1'b0;
   logic          rst_n, flush, e_valid, e_last, e_ready, v_valid, v_ready;
   logic [FL-1:0] e1, e2;
   logic [VW-1:0] v1, v2;
   logic [CW-1:0] cnt;

   typedef struct packed {
      logic [VW-1:0] v1;
      logic [VW-1:0] v2;
      logic [CW-1:0] cnt;
   } exp_t;

   exp_t          sb[$];
   int            n_vec = 0, n_err = 0, cyc = 0;
   logic [VW-1:0] m_v1, m_v2;
   int            m_idx;
   int            ta, tb;

   vector_loader #(.VECTOR_LENGTH(VL), .FIXED_POINT_LENGTH(FL)) dut (
      .clk_in           (clk),
      .reset_i          (rst_n),
      .flush_in         (flush),
      .elem_1_in        (e1),
      .elem_2_in        (e2),
      .elem_valid_in    (e_valid),
      .elem_last_in     (e_last),
      .elem_ready_out   (e_ready),
      .vector_1_out     (v1),
      .vector_2_out     (v2),
      .vector_valid_out (v_valid),
      .vector_ready_in  (v_ready),
      .count_out        (cnt)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [VW-1:0] act, input logic [VW-1:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h want %h", nm, act, exp);
      end
   endtask

   task automatic model_clear();
      m_v1 = '0;
      m_v2 = '0;
      m_idx = 0;
   endtask

   task automatic push_exp();
      exp_t e;
      e.v1 = m_v1;
      e.v2 = m_v2;
      e.cnt = CW'(m_idx);
      sb.push_back(e);
   endtask

   task automatic send(input logic [FL-1:0] a, input logic [FL-1:0] b, input logic last);
      e1 = a; e2 = b; e_last = last; e_valid = 1'b1;
      @(posedge clk); #1;
      m_v1[m_idx*FL +: FL] = a;
      m_v2[m_idx*FL +: FL] = b;
      m_idx++;
      e_valid = 1'b0; e_last = 1'b0;
   endtask

   // Monitor: compare at every consumer handshake.
   always @(negedge clk) begin : mon
      exp_t e;
      if (rst_n && v_valid && v_ready) begin
         if (sb.size() == 0) begin
            n_vec++;
            n_err++;
            $display("FAIL sb_unexpected: got vector %h with nothing expected", v1);
         end else begin
            e = sb.pop_front();
            chk("sb_v1", v1, e.v1);
            chk("sb_v2", v2, e.v2);
            chk("sb_cnt", VW'(cnt), VW'(e.cnt));
         end
      end
   end

   initial begin
      #500000;
      n_err++;
      $display("FAIL watchdog: got timeout want completion");
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n = 1'b1; flush = 1'b0; e_valid = 1'b0; e_last = 1'b0;
      e1 = '0; e2 = '0; v_ready = 1'b0;
      model_clear();
      #2 rst_n = 1'b0;
      #2;
      chk("rst_valid", v_valid, 0);
      chk("rst_cnt", cnt, 0);
      chk("rst_v1", v1, 0);
      chk("rst_v2", v2, 0);
      repeat (2) @(posedge clk);
      #3 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rst_ready", e_ready, 1);

      // full load, last on lane 15
      for (int i = 0; i < 16; i++) send(FL'(i), FL'(16 + i), i == 15);
      chk("full_valid", v_valid, 1);
      chk("full_cnt", cnt, 16);
      chk("full_lane5_v1", v1[5*FL +: FL], 5);
      chk("full_lane5_v2", v2[5*FL +: FL], 21);
      chk("full_v1", v1, m_v1);
      push_exp();

      // backpressure: held vector stable, pairs ignored
      for (int k = 0; k < 5; k++) begin
         e_valid = 1'b1; e_last = 1'b1; e1 = 16'hBEEF; e2 = 16'hCAFE;
         @(posedge clk); #1;
         chk("bp_ready", e_ready, 0);
         chk("bp_valid", v_valid, 1);
         chk("bp_v1", v1, m_v1);
         chk("bp_v2", v2, m_v2);
         chk("bp_cnt", cnt, 16);
      end
      e_valid = 1'b0; e_last = 1'b0; v_ready = 1'b1;
      @(posedge clk); #1;
      v_ready = 1'b0;
      chk("rel_ready", e_ready, 1);
      chk("rel_valid", v_valid, 0);
      chk("rel_v1", v1, 0);
      chk("rel_cnt", cnt, 0);
      model_clear();

      // last without valid is ignored
      e_last = 1'b1;
      @(posedge clk); #1;
      e_last = 1'b0;
      chk("lastnv_ready", e_ready, 1);
      chk("lastnv_cnt", cnt, 0);

      // short vector of three
      send(16'h0400, 16'hF400, 1'b0);
      send(16'h0800, 16'hF800, 1'b0);
      send(16'h0C00, 16'hFC00, 1'b1);
      chk("short_valid", v_valid, 1);
      chk("short_cnt", cnt, 3);
      chk("short_v1", v1, {208'h0, 16'h0C00, 16'h0800, 16'h0400});
      chk("short_v2", v2, {208'h0, 16'hFC00, 16'hF800, 16'hF400});
      push_exp();
      v_ready = 1'b1;
      @(posedge clk); #1;
      v_ready = 1'b0;
      chk("short_rel_valid", v_valid, 0);
      model_clear();

      // back-to-back with ready tied high; second vector has no last flag
      v_ready = 1'b1;
      for (int i = 0; i < 16; i++) send(16'h0100 + FL'(i), 16'hA000 + FL'(i), i == 15);
      ta = cyc;
      chk("b2b_a_valid", v_valid, 1);
      push_exp();
      model_clear();
      e_valid = 1'b1; e1 = 16'hDEAD; e2 = 16'hDEAD;
      @(posedge clk); #1;
      e_valid = 1'b0;
      chk("b2b_gap_valid", v_valid, 0);
      for (int i = 0; i < 16; i++) send(16'hFFFF - FL'(i), FL'(i) * 16'h0111, 1'b0);
      tb = cyc;
      chk("b2b_b_valid", v_valid, 1);
      chk("b2b_b_lane0", v1[FL-1:0], 16'hFFFF);
      push_exp();
      chk("b2b_period", tb - ta, 17);
      @(posedge clk); #1;
      v_ready = 1'b0;
      model_clear();

      // flush after 7 pairs
      for (int i = 0; i < 7; i++) send(16'h3000 + FL'(i), 16'h7000 + FL'(i), 1'b0);
      chk("fl7_cnt", cnt, 7);
      flush = 1'b1; e_valid = 1'b1; e_last = 1'b1; e1 = 16'h1111; e2 = 16'h2222;
      @(posedge clk); #1;
      flush = 1'b0; e_valid = 1'b0; e_last = 1'b0;
      chk("fl7_cnt0", cnt, 0);
      chk("fl7_v1", v1, 0);
      chk("fl7_v2", v2, 0);
      chk("fl7_valid", v_valid, 0);
      chk("fl7_ready", e_ready, 1);
      model_clear();

      // flush while holding
      send(16'h0042, 16'h0024, 1'b0);
      send(16'h0043, 16'h0025, 1'b1);
      chk("flh_valid", v_valid, 1);
      chk("flh_cnt", cnt, 2);
      chk("flh_v1", v1, {224'h0, 16'h0043, 16'h0042});
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      chk("flh_valid0", v_valid, 0);
      chk("flh_cnt0", cnt, 0);
      chk("flh_v1_0", v1, 0);
      model_clear();

      // asynchronous reset mid-fill
      for (int i = 0; i < 5; i++) send(16'h5000 + FL'(i), 16'h6000 + FL'(i), 1'b0);
      chk("rmid_cnt", cnt, 5);
      #3 rst_n = 1'b0;
      #1;
      chk("rmid_cnt0", cnt, 0);
      chk("rmid_v1", v1, 0);
      chk("rmid_v2", v2, 0);
      chk("rmid_valid", v_valid, 0);
      #2 rst_n = 1'b1;
      @(posedge clk); #1;
      chk("rmid_ready", e_ready, 1);
      chk("rmid_cnt_after", cnt, 0);
      model_clear();

      repeat (2) @(posedge clk);
      #1;
      chk("sb_empty", sb.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
